bus3do_fabric: RTL and testbench
================================

Name: bus3do_fabric

Overview:
- Wishbone classic slave fabric directly downstream of the ARM core's Wishbone master.
- Decodes each CPU cycle to one of three targets:
  - MADAM register space
  - CLIO register space
  - external memory port (BIOS/DRAM/VRAM/NVRAM model)
- Generates per-target strobes, waits, collects read data, and returns exactly one ack per accepted cycle.
- Optional bus-timeout reporting.

Parameters:
- REG_WAIT, 1: extra wait cycles after a register strobe before ack (0..15).
- TIMEOUT, 255: memory cycles without i_mem_ack before timeout (1..65535); used only with the optional feature.
- DEAD_DATA, 32'hBADACCE5: read data returned on timeout.

Ports:
- sys_clk  in  1  system clock
- reset_n  in  1  active-low reset
- i_wb_cyc  in  1  Wishbone cycle
- i_wb_stb  in  1  Wishbone strobe
- i_wb_we  in  1  write enable
- i_wb_adr  in  32  byte address
- i_wb_dat  in  32  write data
- i_wb_sel  in  4  byte lanes
- o_wb_ack  out  1  one-cycle acknowledge
- o_wb_dat  out  32  read data, valid while o_wb_ack
- o_madam_rd, o_madam_wr  out  1  one-cycle MADAM strobes
- o_clio_rd, o_clio_wr  out  1  one-cycle CLIO strobes
- o_reg_adr  out  32  latched address to register blocks
- o_reg_dat  out  32  latched write data to register blocks
- i_madam_dout  in  32  MADAM read data
- i_clio_dout  in  32  CLIO read data
- o_mem_req  out  1  memory request, level
- o_mem_we  out  1  memory write
- o_mem_adr  out  32  memory address
- o_mem_dat  out  32  memory write data
- o_mem_sel  out  4  memory byte lanes
- i_mem_ack  in  1  memory done, one cycle
- i_mem_dat  in  32  memory read data, valid with i_mem_ack
- o_bus_err  out  1  one-cycle timeout pulse
- o_err_adr  out  32  address of last timed-out cycle

Behaviour:
- Clock and reset (already decided): single clock sys_clk; reset_n is asynchronous and active-low.
- Reset: all outputs 0; state IDLE; counters 0. Reset mid-cycle abandons the cycle with no ack; o_mem_req drops immediately.
- Address decode:
  - MADAM: 0x03300000–0x0330FFFF.
  - CLIO: 0x03400000–0x0340FFFF.
  - Everything else: memory.
- States: IDLE, REG_STB, REG_WAIT, MEM, ACK, DRAIN.
- IDLE, on cyc&stb:
  - Latch adr/dat/sel/we into o_reg_* and o_mem_*.
  - Register target: go to REG_STB.
  - Memory target: assert o_mem_req and go to MEM.
- REG_STB:
  - Exactly one rd or wr strobe for the decoded target.
  - Go to REG_WAIT, loading wait counter = REG_WAIT.
- REG_WAIT:
  - Decrement the counter.
  - When it is 0: capture the target dout (reads; writes capture 0) into o_wb_dat and go to ACK.
  - With REG_WAIT=0, REG_WAIT lasts one cycle.
  - Register read latency: ack at cycle 3+REG_WAIT after the cycle stb is sampled in IDLE (REG_WAIT=1 gives cycle 4).
- MEM:
  - o_mem_req held high.
  - On i_mem_ack: drop req, capture i_mem_dat (reads), go to ACK.
  - Minimum latency: ack 1 cycle after i_mem_ack.
- ACK: o_wb_ack=1 for exactly one cycle, then IDLE. A new request is accepted in IDLE the cycle after ACK, with no double acceptance.
- Abort (cyc falls before ACK):
  - REG_*: complete internally, suppress ack, return to IDLE.
  - MEM: go to DRAIN; keep o_mem_req until i_mem_ack, then IDLE with no ack. Memory transactions are never cut.
- o_wb_dat holds its last value outside ack. o_reg_*/o_mem_* hold until the next accept.
- i_mem_ack outside MEM/DRAIN is ignored.

Optional Feature:
- Macro: BUS3DO_TIMEOUT_EN.
- With the macro:
  - A 16-bit counter runs in MEM.
  - When the count reaches TIMEOUT with no ack: drop req, o_wb_dat=DEAD_DATA (reads), pulse o_bus_err, latch o_err_adr, go to ACK.
  - If i_mem_ack arrives in the same cycle as the timeout, the ack wins and there is no error.
  - DRAIN also times out, silently.
- Without the macro: no counter; o_bus_err and o_err_adr tied 0; MEM waits indefinitely.

Decomposition:
- Package bus3do_pkg:
  - region base and mask constants (MADAM_BASE, CLIO_BASE, REGION_MASK 0xFFFF0000);
  - target enum {TGT_MEM, TGT_MADAM, TGT_CLIO};
  - state enum;
  - DEAD_DATA default.
- Sub-module bus3do_addr_decode: combinational, address in, target enum out. It is shared later with the DMA master.

Test Plan:
- Read 0x03300004, REG_WAIT=1, i_madam_dout=0x12345678 -> one o_madam_rd pulse at cycle 1; ack at cycle 4 with o_wb_dat=0x12345678; no CLIO or mem activity.
- Write 0x03400020 data 0xA5A5A5A5 -> one o_clio_wr pulse; o_reg_dat=0xA5A5A5A5, o_reg_adr=0x03400020; single ack.
- Read 0x00000100, i_mem_ack 5 cycles after req with i_mem_dat=0xCAFEF00D -> req held 5 cycles; ack the next cycle; data 0xCAFEF00D; sel passed through.
- Timeout (macro on, TIMEOUT=8), no i_mem_ack -> ack with 0xBADACCE5; o_bus_err pulse; o_err_adr = request address. Repeat with i_mem_ack on the timeout cycle -> real data, no error.
- Abort memory cycle: cyc drops 2 cycles after req, i_mem_ack at cycle 6 -> no o_wb_ack; req held until the ack; IDLE afterwards; the next request is serviced normally.
- Assert reset_n=0 mid-MEM -> all outputs 0 asynchronously; after release, back-to-back reads on consecutive ack cycles each return exactly one ack.

Source files
------------

// File: rtl/bus3do_pkg.sv
// bus3do_pkg: shared constants and types for the 3DO Wishbone fabric.
package bus3do_pkg;

  localparam logic [31:0] MADAM_BASE     = 32'h0330_0000;
  localparam logic [31:0] CLIO_BASE      = 32'h0340_0000;
  localparam logic [31:0] REGION_MASK    = 32'hFFFF_0000;
  localparam logic [31:0] DEAD_DATA_DFLT = 32'hBADA_CCE5;

  typedef enum logic [1:0] {
    TGT_MEM,
    TGT_MADAM,
    TGT_CLIO
  } tgt_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REG_STB,
    ST_REG_WAIT,
    ST_MEM,
    ST_ACK,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/bus3do_addr_decode.sv
// bus3do_addr_decode: maps a byte address to its fabric target.
// Purely combinational so the DMA master can reuse it.
module bus3do_addr_decode
  import bus3do_pkg::*;
(
  input  logic [31:0] adr,
  output tgt_e        tgt
);

  // 64 KiB register windows; anything outside them is external memory
  always_comb begin
    tgt = TGT_MEM;
    if ((adr & REGION_MASK) == MADAM_BASE)     tgt = TGT_MADAM;
    else if ((adr & REGION_MASK) == CLIO_BASE) tgt = TGT_CLIO;
  end

endmodule

// File: rtl/bus3do_fabric.sv
// bus3do_fabric: Wishbone classic slave fabric behind the ARM core.
// Routes each cycle to MADAM, CLIO or the external memory port and returns
// exactly one ack per accepted, non-aborted cycle.
// Optional: define BUS3DO_TIMEOUT_EN to enable memory bus-timeout reporting.
module bus3do_fabric
  import bus3do_pkg::*;
#(
  parameter int          REG_WAIT  = 1,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] DEAD_DATA = DEAD_DATA_DFLT
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  output logic        o_wb_ack,
  output logic [31:0] o_wb_dat,
  output logic        o_madam_rd,
  output logic        o_madam_wr,
  output logic        o_clio_rd,
  output logic        o_clio_wr,
  output logic [31:0] o_reg_adr,
  output logic [31:0] o_reg_dat,
  input  logic [31:0] i_madam_dout,
  input  logic [31:0] i_clio_dout,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_adr,
  output logic [31:0] o_mem_dat,
  output logic [3:0]  o_mem_sel,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_dat,
  output logic        o_bus_err,
  output logic [31:0] o_err_adr
);

  state_e      state, state_nxt;
  tgt_e        dec_tgt, tgt_q;
  logic        we_q, aborted;
  logic [31:0] adr_q, dat_q;
  logic [3:0]  sel_q, wait_cnt;
  logic        accept, reg_busy, mem_busy, timeout;
  logic        rsp_load;
  logic [31:0] rsp_dat;

  bus3do_addr_decode u_dec (
    .adr (i_wb_adr),
    .tgt (dec_tgt)
  );

  assign accept   = (state == ST_IDLE) && i_wb_cyc && i_wb_stb;
  assign reg_busy = (state == ST_REG_STB) || (state == ST_REG_WAIT);
  assign mem_busy = (state == ST_MEM) || (state == ST_DRAIN);

`ifdef BUS3DO_TIMEOUT_EN
  logic [15:0] to_cnt;

  // ack arriving on the last allowed cycle takes priority over the timeout
  assign timeout = mem_busy && !i_mem_ack && (to_cnt == 16'(TIMEOUT - 1));

  // cycles spent waiting on memory; DRAIN keeps counting so it can give up too
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n)      to_cnt <= '0;
    else if (mem_busy) to_cnt <= to_cnt + 16'd1;
    else               to_cnt <= '0;
  end

  // error pulse lines up with the ack of the timed-out cycle; drain timeouts stay silent
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      o_bus_err <= 1'b0;
      o_err_adr <= '0;
    end else begin
      o_bus_err <= (state == ST_MEM) && i_wb_cyc && timeout;
      if ((state == ST_MEM) && i_wb_cyc && timeout) o_err_adr <= adr_q;
    end
  end
`else
  assign timeout   = 1'b0;
  assign o_bus_err = 1'b0;
  assign o_err_adr = '0;
`endif

  // state register
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // next state and read-data capture select
  always_comb begin
    state_nxt = state;
    rsp_load  = 1'b0;
    rsp_dat   = '0;
    case (state)
      ST_IDLE:
        if (accept) state_nxt = (dec_tgt == TGT_MEM) ? ST_MEM : ST_REG_STB;
      ST_REG_STB:
        state_nxt = ST_REG_WAIT;
      ST_REG_WAIT:
        if (wait_cnt == '0) begin
          if (aborted || !i_wb_cyc) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_ACK;
            rsp_load  = 1'b1;
            rsp_dat   = we_q ? '0 : ((tgt_q == TGT_MADAM) ? i_madam_dout : i_clio_dout);
          end
        end
      ST_MEM:
        if (i_mem_ack) begin
          state_nxt = i_wb_cyc ? ST_ACK : ST_IDLE;
          rsp_load  = i_wb_cyc && !we_q;
          rsp_dat   = i_mem_dat;
        end else if (timeout) begin
          state_nxt = i_wb_cyc ? ST_ACK : ST_IDLE;
          rsp_load  = i_wb_cyc && !we_q;
          rsp_dat   = DEAD_DATA;
        end else if (!i_wb_cyc) begin
          state_nxt = ST_DRAIN;
        end
      ST_DRAIN:
        if (i_mem_ack || timeout) state_nxt = ST_IDLE;
      ST_ACK:
        state_nxt = ST_IDLE;
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  // request latch; held until the next accept. Abort flag lets a register
  // access finish internally without acking.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      tgt_q   <= TGT_MEM;
      aborted <= 1'b0;
    end else if (accept) begin
      adr_q   <= i_wb_adr;
      dat_q   <= i_wb_dat;
      sel_q   <= i_wb_sel;
      we_q    <= i_wb_we;
      tgt_q   <= dec_tgt;
      aborted <= 1'b0;
    end else if (reg_busy && !i_wb_cyc) begin
      aborted <= 1'b1;
    end
  end

  // register wait counter, loaded on the strobe cycle
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n)                                     wait_cnt <= '0;
    else if (state == ST_REG_STB)                     wait_cnt <= 4'(REG_WAIT);
    else if ((state == ST_REG_WAIT) && (wait_cnt != '0)) wait_cnt <= wait_cnt - 4'd1;
  end

  // read data register; holds between acks
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n)      o_wb_dat <= '0;
    else if (rsp_load) o_wb_dat <= rsp_dat;
  end

  assign o_wb_ack   = (state == ST_ACK);
  assign o_madam_rd = (state == ST_REG_STB) && (tgt_q == TGT_MADAM) && !we_q;
  assign o_madam_wr = (state == ST_REG_STB) && (tgt_q == TGT_MADAM) &&  we_q;
  assign o_clio_rd  = (state == ST_REG_STB) && (tgt_q == TGT_CLIO)  && !we_q;
  assign o_clio_wr  = (state == ST_REG_STB) && (tgt_q == TGT_CLIO)  &&  we_q;
  assign o_reg_adr  = adr_q;
  assign o_reg_dat  = dat_q;
  assign o_mem_req  = mem_busy;
  assign o_mem_we   = we_q;
  assign o_mem_adr  = adr_q;
  assign o_mem_dat  = dat_q;
  assign o_mem_sel  = sel_q;

endmodule

// File: tb/tb_bus3do_fabric.sv
// tb_bus3do_fabric: scoreboarded random + directed bench for bus3do_fabric.
module tb_bus3do_fabric;

  localparam int          RW   = 1;
  localparam int          TO   = 8;
  localparam logic [31:0] DEAD = 32'hBADACCE5;

  logic        sys_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_wb_cyc = 1'b0, i_wb_stb = 1'b0, i_wb_we = 1'b0;
  logic [31:0] i_wb_adr = '0, i_wb_dat = '0;
  logic [3:0]  i_wb_sel = '0;
  logic        o_wb_ack;
  logic [31:0] o_wb_dat;
  logic        o_madam_rd, o_madam_wr, o_clio_rd, o_clio_wr;
  logic [31:0] o_reg_adr, o_reg_dat;
  logic [31:0] i_madam_dout = '0, i_clio_dout = '0, i_mem_dat = '0;
  logic        o_mem_req, o_mem_we;
  logic [31:0] o_mem_adr, o_mem_dat;
  logic [3:0]  o_mem_sel;
  logic        mem_ack_m = 1'b0, spur_ack = 1'b0;
  logic        o_bus_err;
  logic [31:0] o_err_adr;

  always #5 sys_clk = ~sys_clk;

  bus3do_fabric #(.REG_WAIT(RW), .TIMEOUT(TO), .DEAD_DATA(DEAD)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
    .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel),
    .o_wb_ack(o_wb_ack), .o_wb_dat(o_wb_dat),
    .o_madam_rd(o_madam_rd), .o_madam_wr(o_madam_wr),
    .o_clio_rd(o_clio_rd), .o_clio_wr(o_clio_wr),
    .o_reg_adr(o_reg_adr), .o_reg_dat(o_reg_dat),
    .i_madam_dout(i_madam_dout), .i_clio_dout(i_clio_dout),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_adr(o_mem_adr),
    .o_mem_dat(o_mem_dat), .o_mem_sel(o_mem_sel),
    .i_mem_ack(mem_ack_m | spur_ack), .i_mem_dat(i_mem_dat),
    .o_bus_err(o_bus_err), .o_err_adr(o_err_adr)
  );

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
    logic        err;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          vectors = 0, mism = 0;
  int          n_mrd = 0, n_mwr = 0, n_crd = 0, n_cwr = 0, n_req = 0, n_ack = 0;
  logic [31:0] cur_adr = '0, cur_dat = '0;
  logic [3:0]  cur_sel = '0;
  logic        cur_we = 1'b0;
  int          mem_lat = 0, mem_cnt = 0;
  logic [31:0] mem_rdata = '0;

  // 0 = memory, 1 = MADAM, 2 = CLIO, straight from the address map
  function automatic int model_tgt(input logic [31:0] a);
    if (a >= 32'h0330_0000 && a <= 32'h0330_FFFF) return 1;
    if (a >= 32'h0340_0000 && a <= 32'h0340_FFFF) return 2;
    return 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      mism++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // memory model: acks mem_lat cycles after req rises, random data otherwise
  initial forever begin
    @(posedge sys_clk); #1;
    mem_ack_m = 1'b0;
    i_mem_dat = $urandom;
    if (o_mem_req) begin
      if (mem_cnt >= mem_lat) begin
        mem_ack_m = 1'b1;
        i_mem_dat = mem_rdata;
        mem_cnt   = 0;
      end else mem_cnt++;
    end else mem_cnt = 0;
  end

  // side-band monitor: strobe / request counting and latched-field checks
  always @(negedge sys_clk) begin
    if (o_madam_rd) n_mrd++;
    if (o_madam_wr) n_mwr++;
    if (o_clio_rd)  n_crd++;
    if (o_clio_wr)  n_cwr++;
    if (o_madam_rd || o_madam_wr || o_clio_rd || o_clio_wr) begin
      chk("reg_adr", o_reg_adr, cur_adr);
      if (cur_we) chk("reg_dat", o_reg_dat, cur_dat);
    end
    if (o_mem_req) begin
      n_req++;
      chk("mem_adr", o_mem_adr, cur_adr);
      chk("mem_sel", 32'(o_mem_sel), 32'(cur_sel));
      chk("mem_we", 32'(o_mem_we), 32'(cur_we));
      if (cur_we) chk("mem_dat", o_mem_dat, cur_dat);
    end
    if (o_bus_err && !o_wb_ack) begin
      vectors++; mism++;
      $display("FAIL bus_err_pulse: o_bus_err=1 without ack, expected 0");
    end
  end

  // scoreboard monitor: every ack pops one expected response
  always @(negedge sys_clk) begin
    if (o_wb_ack) begin
      n_ack++;
      if (q.size() == 0) begin
        vectors++; mism++;
        $display("FAIL unexpected_ack: ack with empty scoreboard at adr %h", o_reg_adr);
      end else begin
        mon_e = q.pop_front();
        if (!mon_e.we) chk("rdata", o_wb_dat, mon_e.dat);
        chk("bus_err", 32'(o_bus_err), 32'(mon_e.err));
        if (mon_e.err) chk("err_adr", o_err_adr, mon_e.adr);
      end
    end
  end

  // one Wishbone cycle; called at posedge+1 with the fabric idle
  task automatic do_cycle(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                          input logic [3:0] sel, input logic [31:0] rdat, input int lat,
                          input logic tmo);
    int   tgt, cnt, exp_lat, exp_req;
    exp_t e;
    tgt          = model_tgt(adr);
    i_madam_dout = (tgt == 1) ? rdat : $urandom;
    i_clio_dout  = (tgt == 2) ? rdat : $urandom;
    mem_rdata    = rdat;
    mem_lat      = tmo ? 100000 : lat;
    cur_adr = adr; cur_dat = dat; cur_sel = sel; cur_we = we;
    n_mrd = 0; n_mwr = 0; n_crd = 0; n_cwr = 0; n_req = 0;
    e.adr = adr; e.we = we; e.dat = tmo ? DEAD : rdat; e.err = tmo;
    q.push_back(e);
    i_wb_adr = adr; i_wb_dat = dat; i_wb_sel = sel; i_wb_we = we;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
    cnt = 0;
    while (1) begin
      @(negedge sys_clk);
      if (o_wb_ack) break;
      cnt++;
      if (cnt > 300) begin
        vectors++; mism++;
        $display("FAIL ack_wait: no ack after %0d cycles for adr %h", cnt, adr);
        q.delete();
        break;
      end
    end
    @(posedge sys_clk); #1;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    exp_lat = (tgt != 0) ? 3 + RW : (tmo ? TO + 1 : lat + 2);
    exp_req = (tgt != 0) ? 0 : (tmo ? TO : lat + 1);
    chk("ack_latency", 32'(cnt), 32'(exp_lat));
    chk("madam_rd_cnt", 32'(n_mrd), 32'(tgt == 1 && !we));
    chk("madam_wr_cnt", 32'(n_mwr), 32'(tgt == 1 && we));
    chk("clio_rd_cnt", 32'(n_crd), 32'(tgt == 2 && !we));
    chk("clio_wr_cnt", 32'(n_cwr), 32'(tgt == 2 && we));
    chk("mem_req_cycles", 32'(n_req), 32'(exp_req));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [31:0] bnd [8];
    int          gap;
    bnd = '{32'h032F_FFFC, 32'h0330_0000, 32'h0330_FFFC, 32'h0331_0000,
            32'h033F_FFFC, 32'h0340_0000, 32'h0340_FFFF, 32'h0341_0000};

    // reset state
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_ack", 32'(o_wb_ack), 32'd0);
    chk("rst_req", 32'(o_mem_req), 32'd0);
    chk("rst_wb_dat", o_wb_dat, 32'd0);
    chk("rst_reg_adr", o_reg_adr, 32'd0);
    reset_n = 1'b1;
    @(posedge sys_clk); #1;

    // directed: MADAM read, CLIO write, memory read with byte lanes
    do_cycle(32'h0330_0004, 1'b0, 32'h0, 4'hF, 32'h1234_5678, 0, 1'b0);
    do_cycle(32'h0340_0020, 1'b1, 32'hA5A5_A5A5, 4'hF, 32'h0, 0, 1'b0);
    do_cycle(32'h0000_0100, 1'b0, 32'h0, 4'b0110, 32'hCAFE_F00D, 4, 1'b0);

    // region boundaries
    foreach (bnd[i]) do_cycle(bnd[i], 1'b0, 32'h0, 4'hF, $urandom, 1, 1'b0);

    // randomized mix with optional idle gaps
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 2))
        0:       a = {16'h0330, 16'($urandom)};
        1:       a = {16'h0340, 16'($urandom)};
        default: a = $urandom;
      endcase
      do_cycle(a, 1'($urandom), $urandom, 4'($urandom), $urandom, $urandom_range(0, 6), 1'b0);
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        repeat (gap) @(posedge sys_clk);
        #1;
      end
    end

    // memory ack while idle must be ignored
    n_ack = 0;
    spur_ack = 1'b1;
    @(posedge sys_clk); #1;
    spur_ack = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("spurious_mem_ack", 32'(n_ack), 32'd0);
    chk("spurious_req", 32'(o_mem_req), 32'd0);

    // abort a memory cycle: req stays until memory acks, no wb ack
    n_ack = 0; n_req = 0;
    cur_adr = 32'h0000_2000; cur_we = 1'b0; cur_sel = 4'hF; cur_dat = '0;
    mem_lat = 5; mem_rdata = $urandom;
    i_wb_adr = cur_adr; i_wb_we = 1'b0; i_wb_sel = 4'hF; i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    repeat (10) @(posedge sys_clk);
    #1;
    chk("abort_mem_ack", 32'(n_ack), 32'd0);
    chk("abort_req_cycles", 32'(n_req), 32'd6);
    do_cycle(32'h0000_2004, 1'b0, 32'h0, 4'hF, 32'h0BAD_F00D, 2, 1'b0);

    // abort a register write: strobe still fires once, no ack
    n_ack = 0; n_cwr = 0;
    cur_adr = 32'h0340_0040; cur_we = 1'b1; cur_dat = 32'h5A5A_0001; cur_sel = 4'hF;
    i_wb_adr = cur_adr; i_wb_we = 1'b1; i_wb_dat = cur_dat; i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
    @(posedge sys_clk); #1;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    repeat (6) @(posedge sys_clk);
    #1;
    chk("abort_reg_ack", 32'(n_ack), 32'd0);
    chk("abort_reg_strobe", 32'(n_cwr), 32'd1);

`ifdef BUS3DO_TIMEOUT_EN
    do_cycle(32'h0000_4000, 1'b0, 32'h0, 4'hF, $urandom, 0, 1'b1);
    do_cycle(32'h0000_4004, 1'b0, 32'h0, 4'hF, 32'h600D_DA7A, TO - 1, 1'b0);
    do_cycle(32'h0000_4008, 1'b1, 32'h1357_9BDF, 4'h3, 32'h0, 0, 1'b1);
`else
    do_cycle(32'h0000_4000, 1'b0, 32'h0, 4'hF, 32'h600D_DA7A, 20, 1'b0);
    chk("no_err_adr", o_err_adr, 32'd0);
`endif

    // asynchronous reset in the middle of a memory cycle
    cur_adr = 32'h0000_3000; cur_we = 1'b0; cur_sel = 4'h9; cur_dat = '0;
    mem_lat = 50;
    i_wb_adr = cur_adr; i_wb_we = 1'b0; i_wb_sel = cur_sel; i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
    repeat (3) @(posedge sys_clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_req", 32'(o_mem_req), 32'd0);
    chk("arst_ack", 32'(o_wb_ack), 32'd0);
    chk("arst_wb_dat", o_wb_dat, 32'd0);
    chk("arst_mem_adr", o_mem_adr, 32'd0);
    chk("arst_mem_sel", 32'(o_mem_sel), 32'd0);
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    @(posedge sys_clk); #1;
    reset_n = 1'b1;
    @(posedge sys_clk); #1;

    // back-to-back reads after reset
    do_cycle(32'h0330_0010, 1'b0, 32'h0, 4'hF, $urandom, 0, 1'b0);
    do_cycle(32'h0000_0200, 1'b0, 32'h0, 4'hF, $urandom, 0, 1'b0);
    do_cycle(32'h0340_0008, 1'b0, 32'h0, 4'hF, $urandom, 0, 1'b0);
    do_cycle(32'h0000_0204, 1'b0, 32'h0, 4'hF, $urandom, 3, 1'b0);

    repeat (4) @(posedge sys_clk);
    #1;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, mism);
    $finish;
  end

endmodule
